accum_32bit_seq: RTL and testbench

Sequential multi-word accumulator that feeds signed 16-bit operand words through a 16-bit add datapath, two cycles per word, into a 32-bit running sum. Each word is added as a low-half add followed by a high-half add with carry. At the end of a programmed run it reports the 32-bit result with the same flag set the 16-bit adder produces: sign, zero, carry, parity and overflow. It is the stage downstream of the operand source and upstream of the status/flag consumers.

---
 rtl/accum_32bit_seq.sv | 93 +++++++++
 tb/tb_accum_32bit_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/accum_32bit_seq.sv
// accum_32bit_seq: accumulates signed 16-bit words into a 32-bit sum over a 16-bit datapath, two cycles per word
module accum_32bit_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      init_val,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sum,
  output logic             s,
  output logic             zr,
  output logic             cy,
  output logic             p,
  output logic             v
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t           state_q;
  logic [31:0]      acc_q;
  logic [CNT_W-1:0] rem_q;
  logic             c16_q, sb_q, cy_q, v_q;
  logic [16:0]      lo_sum, hi_sum;
  logic [31:0]      acc_hi, fin_val;
  logic             cy_d, v_d, fin_cy, fin_v, publish;
  assign lo_sum  = {1'b0, acc_q[15:0]} + {1'b0, in_data};
  assign hi_sum  = {1'b0, acc_q[31:16]} + {1'b0, {16{sb_q}}} + 17'(c16_q);
  assign acc_hi  = {hi_sum[15:0], acc_q[15:0]};
  assign cy_d    = cy_q | hi_sum[16];
  assign v_d     = v_q | ((acc_q[31] == sb_q) && (hi_sum[15] != acc_q[31]));
  // A zero-length run publishes init_val straight from IDLE; otherwise the last high-half add publishes
  assign publish = (state_q == IDLE && start && count == '0) || (state_q == HIGH && rem_q == CNT_W'(1));
  assign fin_val = (state_q == IDLE) ? init_val : acc_hi;
  assign fin_cy  = (state_q == IDLE) ? 1'b0 : cy_d;
  assign fin_v   = (state_q == IDLE) ? 1'b0 : v_d;
  assign in_ready = (state_q == LOW);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  // Control FSM, split low/high half adds, and result/flag registers loaded on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      c16_q   <= 1'b0;
      sb_q    <= 1'b0;
      cy_q    <= 1'b0;
      v_q     <= 1'b0;
      sum     <= '0;
      s       <= 1'b0;
      zr      <= 1'b0;
      cy      <= 1'b0;
      p       <= 1'b0;
      v       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          acc_q   <= init_val;
          rem_q   <= count;
          cy_q    <= 1'b0;
          v_q     <= 1'b0;
          state_q <= (count == '0) ? DONE : LOW;
        end
        LOW: if (in_valid) begin
          acc_q[15:0] <= lo_sum[15:0];
          c16_q       <= lo_sum[16];
          sb_q        <= in_data[15];
          state_q     <= HIGH;
        end
        HIGH: begin
          acc_q   <= acc_hi;
          cy_q    <= cy_d;
          v_q     <= v_d;
          rem_q   <= rem_q - CNT_W'(1);
          state_q <= (rem_q == CNT_W'(1)) ? DONE : LOW;
        end
        DONE: state_q <= IDLE;
      endcase
      if (publish) begin
        sum <= fin_val;
        s   <= fin_val[31];
        zr  <= (fin_val == '0);
        cy  <= fin_cy;
        p   <= ~^fin_val;
        v   <= fin_v;
      end
    end
  end
endmodule

// File: tb/tb_accum_32bit_seq.sv
// tb_accum_32bit_seq: randomized and directed runs checked against a 32-bit arithmetic reference model
module tb_accum_32bit_seq;
  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  count;
  logic [31:0] init_val;
  logic [15:0] in_data;
  logic        in_ready, busy, done;
  logic [31:0] sum;
  logic        s, zr, cy, p, v;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] words [256];

  accum_32bit_seq #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .init_val(init_val),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .done(done), .sum(sum), .s(s), .zr(zr), .cy(cy), .p(p), .v(v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full run: model computes the expected 32-bit sum and sticky flags with plain wide arithmetic
  task automatic run(input logic [31:0] init, input int cnt, input bit noisy);
    logic [31:0] e_acc, w;
    logic [32:0] r;
    logic        e_cy, e_v, stalled;
    int          idx, cyc;
    e_acc = init; e_cy = 1'b0; e_v = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      w = {{16{words[i][15]}}, words[i]};
      r = {1'b0, e_acc} + {1'b0, w};
      e_cy |= r[32];
      e_v  |= (e_acc[31] == w[31]) && (r[31] != e_acc[31]);
      e_acc = r[31:0];
    end
    start = 1'b1; count = 8'(cnt); init_val = init; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1; idx = 0; stalled = 1'b0;
    while (!done && cyc < 2000) begin
      if (stalled) chk("stall_ready", {31'b0, in_ready}, 32'd1);
      stalled = 1'b0;
      if (in_ready) begin
        if (noisy && $urandom_range(0, 2) == 0) begin
          in_valid = 1'b0; in_data = 16'($urandom); stalled = 1'b1;
        end else begin
          in_valid = 1'b1; in_data = words[idx]; idx++;
        end
      end else begin
        in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = 16'($urandom);
        start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        count    = 8'($urandom_range(0, 5));
        init_val = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0; cyc++;
    end
    in_valid = 1'b0;
    chk("done", {31'b0, done}, 32'd1);
    if (!noisy) chk("latency", 32'(cyc), 32'(2 * cnt + 1));
    chk("words_used", 32'(idx), 32'(cnt));
    chk("sum", sum, e_acc);
    chk("flags", {27'b0, s, zr, cy, p, v}, {27'b0, e_acc[31], e_acc == 0, e_cy, ~^e_acc, e_v});
    start = 1'b1; count = 8'd3; init_val = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_done_idle", {30'b0, busy, done}, 32'd0);
    @(posedge clk); #1;
    chk("sum_hold", sum, e_acc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; init_val = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ctrl", {29'b0, in_ready, busy, done}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", {27'b0, s, zr, cy, p, v}, 32'd0);
    words[0] = 16'h7FFF; words[1] = 16'h0001;
    run(32'd0, 2, 1'b0);
    chk("tp1_sum", sum, 32'h0000_8000);
    words[0] = 16'hFFFF; words[1] = 16'h0001;
    run(32'd0, 2, 1'b0);
    chk("tp2_flags", {27'b0, s, zr, cy, p, v}, 32'b01110);
    words[0] = 16'h8000;
    run(32'd0, 1, 1'b0);
    chk("tp3_sum", sum, 32'hFFFF_8000);
    words[0] = 16'h0010;
    run(32'h7FFF_FFF0, 1, 1'b0);
    chk("tp4_flags", {27'b0, s, zr, cy, p, v}, 32'b10001);
    run(32'h1234_5678, 0, 1'b0);
    chk("tp_zero_cnt", sum, 32'h1234_5678);
    words[0] = 16'h7FFF; words[1] = 16'h0001;
    run(32'd0, 2, 1'b1);
    chk("tp5_sum", sum, 32'h0000_8000);
    for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
    start = 1'b1; count = 8'd3; init_val = $urandom;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = words[0];
    @(posedge clk); #1;
    in_data = words[1];
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_high", {30'b0, in_ready, busy}, 32'd1);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ctrl", {29'b0, in_ready, busy, done}, 32'd0);
    chk("mid_rst_sum", sum, 32'd0);
    chk("mid_rst_flags", {27'b0, s, zr, cy, p, v}, 32'd0);
    run(32'hFFFF_FFFF, 3, 1'b0);
    for (int n = 0; n < 40; n++) begin
      int cnt;
      cnt = $urandom_range(0, 12);
      for (int i = 0; i < cnt; i++)
        case ($urandom_range(0, 4))
          0: words[i] = 16'h7FFF;
          1: words[i] = 16'h8000;
          2: words[i] = 16'hFFFF;
          default: words[i] = 16'($urandom);
        endcase
      run(($urandom_range(0, 1) == 1) ? 32'h7FFF_0000 + $urandom_range(0, 65535) : $urandom, cnt, 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
